// File: rtl/exc_ctrl_pkg.sv
// Shared constants for exc_ctrl: cause codes, mem_exc bit positions, CP0 write-enable
// indices, default exception vector and FSM / bad-address-select encodings.
package exc_ctrl_pkg;

  localparam logic [31:0] DEF_EXC_VECTOR = 32'hBFC00380;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int EXC_BIT_ADEL_IF = 6;
  localparam int EXC_BIT_RI      = 5;
  localparam int EXC_BIT_OV      = 4;
  localparam int EXC_BIT_SYS     = 3;
  localparam int EXC_BIT_BP      = 2;
  localparam int EXC_BIT_ADEL_D  = 1;
  localparam int EXC_BIT_ADES    = 0;

  localparam int CP0_WE_BADADDR = 8;
  localparam int CP0_WE_STATUS  = 12;
  localparam int CP0_WE_CAUSE   = 13;
  localparam int CP0_WE_EPC     = 14;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  typedef enum logic [1:0] {
    BAD_NONE = 2'd0,
    BAD_PC   = 2'd1,
    BAD_DATA = 2'd2
  } bad_sel_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational event priority encoder: interrupt > fetch AdEL > RI > Ov > Sys > Bp > data AdEL > AdES > ERET.
// Zero latency, no handshake.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       int_pending,
  input  logic [6:0] mem_exc,
  input  logic       mem_eret,
  output logic       evt_vld,
  output logic       evt_eret,
  output logic [4:0] evt_code,
  output bad_sel_e   bad_sel
);

  always_comb begin
    evt_vld  = 1'b1;
    evt_eret = 1'b0;
    evt_code = EXC_INT;
    bad_sel  = BAD_NONE;
    if (int_pending) begin
      evt_code = EXC_INT;
    end else if (mem_exc[EXC_BIT_ADEL_IF]) begin
      evt_code = EXC_ADEL;
      bad_sel  = BAD_PC;
    end else if (mem_exc[EXC_BIT_RI]) begin
      evt_code = EXC_RI;
    end else if (mem_exc[EXC_BIT_OV]) begin
      evt_code = EXC_OV;
    end else if (mem_exc[EXC_BIT_SYS]) begin
      evt_code = EXC_SYS;
    end else if (mem_exc[EXC_BIT_BP]) begin
      evt_code = EXC_BP;
    end else if (mem_exc[EXC_BIT_ADEL_D]) begin
      evt_code = EXC_ADEL;
      bad_sel  = BAD_DATA;
    end else if (mem_exc[EXC_BIT_ADES]) begin
      evt_code = EXC_ADES;
      bad_sel  = BAD_DATA;
    end else if (mem_eret) begin
      evt_eret = 1'b1;
    end else begin
      evt_vld  = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: one-cycle CP0 write + flush pulse, then a held fetch redirect.
// Redirect waits on redirect_ready; events while busy are dropped. EXC_TIMER_INT_EN ORs timer into hw line 5.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       hardware_interruption,
  input  logic             mem_valid,
  input  logic [WIDTH-1:0] mem_pc,
  input  logic             mem_in_delay_slot,
  input  logic [6:0]       mem_exc,
  input  logic             mem_eret,
  input  logic [WIDTH-1:0] mem_badaddr,
  input  logic [WIDTH-1:0] Status_data,
  input  logic [WIDTH-1:0] cause_data,
  input  logic [WIDTH-1:0] EPC_data,
  input  logic             timer_int_data,
  output logic [WIDTH-1:0] we,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] BADADDR,
  output logic [4:0]       Exception_code,
  output logic             Branch_delay,
  output logic             EXL,
  output logic             IE,
  output logic [7:0]       interrupt_enable,
  output logic [5:0]       hw_int_out,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  input  logic             redirect_ready,
  output logic             busy
);

  exc_state_e       state_q, state_d;
  logic [5:0]       hw_meta_q, hw_meta_d, hw_sync_q, hw_sync_d;
  logic [5:0]       hw_sync;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] we_q, we_d, epc_q, epc_d, badaddr_q, badaddr_d;
  logic [WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic [4:0]       code_q, code_d;
  logic [7:0]       ie8_q, ie8_d;
  logic             bd_q, bd_d, exl_q, exl_d, ie_q, ie_d;
  logic             flush_q, flush_d, redir_vld_q, redir_vld_d, busy_q, busy_d;

  logic             int_pending, evt_vld, evt_eret;
  logic [4:0]       evt_code;
  bad_sel_e         bad_sel;

`ifdef EXC_TIMER_INT_EN
  assign hw_sync = {hw_sync_q[5] | timer_int_data, hw_sync_q[4:0]};
`else
  assign hw_sync = hw_sync_q;
  logic unused_timer;
  assign unused_timer = timer_int_data;
`endif

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{Status_data[WIDTH-1:16], Status_data[7:2],
                             cause_data[WIDTH-1:10], cause_data[7:0]};

  // Mask lines are {hw[5:0], sw[1:0]} against Status.IM; blocked while EXL is set.
  assign int_pending = Status_data[0] && !Status_data[1] &&
                       ((Status_data[15:8] & {hw_sync, cause_data[9:8]}) != 8'd0);

  exc_prio_enc u_prio_enc (
    .int_pending (int_pending),
    .mem_exc     (mem_exc),
    .mem_eret    (mem_eret),
    .evt_vld     (evt_vld),
    .evt_eret    (evt_eret),
    .evt_code    (evt_code),
    .bad_sel     (bad_sel)
  );

  always_comb begin
    hw_meta_d   = hardware_interruption;
    hw_sync_d   = hw_meta_q;
    state_d     = state_q;
    target_d    = target_q;
    flush_d     = 1'b0;
    we_d        = '0;
    epc_d       = '0;
    badaddr_d   = '0;
    code_d      = '0;
    bd_d        = 1'b0;
    exl_d       = 1'b0;
    ie_d        = 1'b0;
    ie8_d       = '0;
    redir_vld_d = 1'b0;
    redir_pc_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid && evt_vld) begin
          state_d               = ST_FLUSH;
          flush_d               = 1'b1;
          we_d[CP0_WE_STATUS]   = 1'b1;
          ie_d                  = Status_data[0];
          ie8_d                 = Status_data[15:8];
          if (evt_eret) begin
            target_d = EPC_data;
          end else begin
            target_d              = EXC_VECTOR;
            we_d[CP0_WE_CAUSE]    = 1'b1;
            we_d[CP0_WE_EPC]      = 1'b1;
            we_d[CP0_WE_BADADDR]  = (bad_sel != BAD_NONE);
            epc_d                 = mem_pc;
            bd_d                  = mem_in_delay_slot;
            code_d                = evt_code;
            exl_d                 = 1'b1;
            if (bad_sel == BAD_PC)        badaddr_d = mem_pc;
            else if (bad_sel == BAD_DATA) badaddr_d = mem_badaddr;
          end
        end
      end
      ST_FLUSH: begin
        state_d     = ST_REDIRECT;
        redir_vld_d = 1'b1;
        redir_pc_d  = target_q;
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d  = ST_IDLE;
          target_d = '0;
        end else begin
          redir_vld_d = 1'b1;
          redir_pc_d  = target_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hw_meta_q   <= '0;
      hw_sync_q   <= '0;
      target_q    <= '0;
      flush_q     <= 1'b0;
      we_q        <= '0;
      epc_q       <= '0;
      badaddr_q   <= '0;
      code_q      <= '0;
      bd_q        <= 1'b0;
      exl_q       <= 1'b0;
      ie_q        <= 1'b0;
      ie8_q       <= '0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hw_meta_q   <= hw_meta_d;
      hw_sync_q   <= hw_sync_d;
      target_q    <= target_d;
      flush_q     <= flush_d;
      we_q        <= we_d;
      epc_q       <= epc_d;
      badaddr_q   <= badaddr_d;
      code_q      <= code_d;
      bd_q        <= bd_d;
      exl_q       <= exl_d;
      ie_q        <= ie_d;
      ie8_q       <= ie8_d;
      redir_vld_q <= redir_vld_d;
      redir_pc_q  <= redir_pc_d;
      busy_q      <= busy_d;
    end
  end

  assign we               = we_q;
  assign epc              = epc_q;
  assign BADADDR          = badaddr_q;
  assign Exception_code   = code_q;
  assign Branch_delay     = bd_q;
  assign EXL              = exl_q;
  assign IE               = ie_q;
  assign interrupt_enable = ie8_q;
  assign hw_int_out       = hw_sync;
  assign flush            = flush_q;
  assign redirect_valid   = redir_vld_q;
  assign redirect_pc      = redir_pc_q;
  assign busy             = busy_q;

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, datapath width.
REQ-002 Parameter EXC_VECTOR, default 32'hBFC00380, general exception entry PC.
REQ-003 One clock; reset is asynchronous and active-high; ports clk, rst.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 hardware_interruption  in  6  asynchronous external interrupt lines.
REQ-007 mem_valid  in  1  MEM-stage instruction valid.
REQ-008 mem_pc  in  WIDTH  MEM-stage instruction PC.
REQ-009 mem_in_delay_slot  in  1  MEM instruction sits in a delay slot.
REQ-010 mem_exc  in  7  {AdEL-fetch, RI, Ov, Sys, Bp, AdEL-data, AdES}, bit 6 to bit 0.
REQ-011 mem_eret  in  1  MEM instruction is ERET.
REQ-012 mem_badaddr  in  WIDTH  faulting data address.
REQ-013 Status_data, cause_data, EPC_data  in  WIDTH each  current CP0 values.
REQ-014 timer_int_data  in  1  CP0 timer interrupt.
REQ-015 we  out  WIDTH  CP0 per-register write enables.
REQ-016 epc, BADADDR  out  WIDTH each  CP0 write data.
REQ-017 Exception_code  out  5; Branch_delay, EXL, IE  out  1 each; interrupt_enable  out  8; hw_int_out  out  6  CP0 write fields.
REQ-018 flush  out  1  pipeline flush pulse.
REQ-019 redirect_valid  out  1; redirect_pc  out  WIDTH; redirect_ready  in  1  fetch redirect handshake.
REQ-020 busy  out  1  state is not IDLE.

Function
REQ-021 hardware_interruption SHALL pass through a 2-flop synchronizer; the synchronized value drives hw_int_out.
REQ-022 Interrupt pending SHALL be Status[0]=1, Status[1]=0 and (Status[15:8] & {hw_sync, cause_data[9:8]}) != 0.
REQ-023 Priority SHALL be interrupt > AdEL-fetch > RI > Ov > Sys > Bp > AdEL-data > AdES > ERET; codes Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
REQ-024 FSM states SHALL be IDLE, FLUSH, REDIRECT.
REQ-025 In IDLE with mem_valid=1 and an event: next cycle the FSM enters FLUSH, and flush=1 and we are pulsed for exactly that cycle.
REQ-026 Exception or interrupt write: we[12], we[13], we[14] set; we[8] also set for AdEL/AdES only.
REQ-027 Exception or interrupt write data: epc=mem_pc, Branch_delay=mem_in_delay_slot, Exception_code per REQ-023, EXL=1, IE=Status[0], interrupt_enable=Status[15:8].
REQ-028 The -4 delay-slot adjustment of epc is done by CP0; this block passes the PC unadjusted.
REQ-029 BADADDR SHALL be mem_pc for AdEL-fetch and mem_badaddr for AdEL-data/AdES.
REQ-030 ERET: only we[12] set; EXL=0, IE and interrupt_enable unchanged; redirect target EPC_data sampled at detection.
REQ-031 FLUSH lasts one cycle, then REDIRECT.
REQ-032 In REDIRECT, redirect_valid=1 and redirect_pc stays stable (EXC_VECTOR or the latched EPC) until redirect_ready=1; the FSM then returns to IDLE.
REQ-033 Events arriving while busy=1 SHALL be ignored (the pipeline is being flushed).
REQ-034 mem_valid=0 SHALL suppress all events, including interrupts.
REQ-035 Outside the pulse cycle, all we bits and write-data outputs SHALL be 0.

Reset
REQ-036 rst SHALL force IDLE, clear the synchronizer and latched target, and drive every output to 0 (hw_int_out=0, redirect_pc=0).
REQ-037 rst asserted mid-FLUSH or mid-REDIRECT SHALL abort the sequence with no further we pulse.

Configuration
REQ-038 With EXC_TIMER_INT_EN defined, hw_sync[5] SHALL be the synchronized hardware_interruption[5] OR timer_int_data.
REQ-039 Without EXC_TIMER_INT_EN, timer_int_data SHALL be ignored.

Structure
REQ-040 A shared package SHALL hold the exception code constants, the FSM state encoding, EXC_VECTOR, and the mem_exc bit indices.
REQ-041 One sub-module exc_prio_enc (combinational priority encoder: code, badaddr select, event valid) SHALL be instantiated.

Verification
REQ-042 Bench: mem_exc=7'b0001000 (Sys), mem_pc=32'h80001000, delay slot 0 -> one-cycle we=0x7000, Exception_code=8, epc=32'h80001000, EXL=1, flush=1; then redirect_pc=32'hBFC00380.
REQ-043 Bench: AdES, mem_badaddr=32'h80002003 -> we bit 8 set, BADADDR=32'h80002003, code=5.
REQ-044 Bench: Status=32'h0000FF01, hardware_interruption[2]=1 concurrent with Ov -> after sync, code=0 (interrupt wins).
REQ-045 Bench: ERET, EPC_data=32'h80000040; redirect_ready held low 3 cycles -> redirect_valid stays high with redirect_pc=32'h80000040; on ready, back to IDLE; we=0x1000 with EXL=0.
REQ-046 Bench: Sys event during REDIRECT -> ignored; rst asserted in FLUSH -> all outputs 0 next edge.
